// File: rtl/ooo_read_responder.sv
// Read-side AXI-like target: AR requests go into a slot table, each with an
// ID-dependent latency, and single-beat R responses are returned out of order.
module ooo_read_responder #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int SLOTS      = 4,
    parameter int LAT_BASE   = 1,
    parameter int LAT_STEP   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            s_arid_i,
    input  logic [ADDR_WIDTH-1:0] s_araddr_i,
    input  logic                  s_arvalid_i,
    output logic                  s_arready_o,
    output logic [DATA_WIDTH-1:0] s_rdata_o,
    output logic [3:0]            s_rid_o,
    output logic                  s_rvalid_o,
    input  logic                  s_rready_i
);

    localparam int LAT_MAX = LAT_BASE + 3 * LAT_STEP;
    localparam int CNT_W   = (LAT_MAX < 1) ? 1 : $clog2(LAT_MAX + 1);
    localparam int IDX_W   = (SLOTS < 2) ? 1 : $clog2(SLOTS);

    logic [SLOTS-1:0]      slot_valid;
    logic [3:0]            slot_id   [SLOTS];
    logic [ADDR_WIDTH-1:0] slot_addr [SLOTS];
    logic [CNT_W-1:0]      slot_cnt  [SLOTS];

    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             elig_found;
    logic [IDX_W-1:0] elig_idx;
    logic             id_hit;
    logic             accept;
    logic             load;
    logic [CNT_W-1:0] new_lat;
    logic [DATA_WIDTH-1:0] beat_data;

    // Lowest-index free slot, lowest-index eligible slot and ID collision scan.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        elig_found = 1'b0;
        elig_idx   = '0;
        id_hit     = 1'b0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (!slot_valid[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (slot_valid[i] && (slot_cnt[i] == '0) && !elig_found) begin
                elig_found = 1'b1;
                elig_idx   = IDX_W'(i);
            end
            if (slot_valid[i] && (slot_id[i] == s_arid_i))
                id_hit = 1'b1;
        end
    end

    assign s_arready_o = !rst && free_found && !id_hit;
    assign accept      = s_arvalid_i && s_arready_o;
    assign load        = elig_found && (!s_rvalid_o || s_rready_i);
    assign new_lat     = CNT_W'(LAT_BASE + LAT_STEP * (3 - int'(s_arid_i[1:0])));
    assign beat_data   = DATA_WIDTH'(slot_addr[elig_idx]) + DATA_WIDTH'(slot_id[elig_idx]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid <= '0;
            for (int unsigned i = 0; i < SLOTS; i++) begin
                slot_id[i]   <= '0;
                slot_addr[i] <= '0;
                slot_cnt[i]  <= '0;
            end
            s_rvalid_o <= 1'b0;
            s_rdata_o  <= '0;
            s_rid_o    <= '0;
        end else begin
            for (int unsigned i = 0; i < SLOTS; i++) begin
                if (slot_valid[i] && (slot_cnt[i] != '0))
                    slot_cnt[i] <= slot_cnt[i] - CNT_W'(1);
            end
            if (load) begin
                slot_valid[elig_idx] <= 1'b0;
                s_rvalid_o           <= 1'b1;
                s_rid_o              <= slot_id[elig_idx];
                s_rdata_o            <= beat_data;
            end else if (s_rvalid_o && s_rready_i) begin
                s_rvalid_o <= 1'b0;
            end
            // The accepted slot is always invalid, so it never collides with the loaded one.
            if (accept) begin
                slot_valid[free_idx] <= 1'b1;
                slot_id[free_idx]    <= s_arid_i;
                slot_addr[free_idx]  <= s_araddr_i;
                slot_cnt[free_idx]   <= new_lat;
            end
        end
    end

endmodule

// File: tb/tb_ooo_read_responder.sv
// Bench for ooo_read_responder: timestamp-based reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_ooo_read_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] arid = '0;
    logic [7:0] araddr = '0;
    logic       arvalid = 1'b0;
    logic       arready;
    logic [7:0] rdata;
    logic [3:0] rid;
    logic       rvalid;
    logic       rready = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    ooo_read_responder #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(8),
        .SLOTS(4),
        .LAT_BASE(1),
        .LAT_STEP(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_arid_i(arid),
        .s_araddr_i(araddr),
        .s_arvalid_i(arvalid),
        .s_arready_o(arready),
        .s_rdata_o(rdata),
        .s_rid_o(rid),
        .s_rvalid_o(rvalid),
        .s_rready_i(rready)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    // Reference model: each request carries the edge number after which it is eligible.
    typedef struct {
        bit       v;
        bit [3:0] id;
        bit [7:0] addr;
        int       due;
    } ent_t;

    ent_t     m_tab[4];
    bit       m_rv;
    bit [3:0] m_rid;
    bit [7:0] m_rd;
    int       cyc;

    function automatic int lat(bit [3:0] id);
        return 1 + 2 * (3 - int'(id[1:0]));
    endfunction

    function automatic bit m_ready();
        bit fr, hit;
        fr = 0;
        hit = 0;
        if (rst) return 0;
        for (int i = 0; i < 4; i++) begin
            if (!m_tab[i].v) fr = 1;
            else if (m_tab[i].id == arid) hit = 1;
        end
        return fr && !hit;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        ent_t t[4];
        int   fi, ei, e;
        bit   acc;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_tab[i].v <= 0;
            m_rv  <= 0;
            m_rid <= '0;
            m_rd  <= '0;
        end else begin
            e = cyc + 1;
            cyc <= e;
            acc = arvalid && m_ready();
            t = m_tab;
            fi = -1;
            ei = -1;
            for (int i = 0; i < 4; i++) begin
                if (!t[i].v && fi < 0) fi = i;
                if (t[i].v && e > t[i].due && ei < 0) ei = i;
            end
            if ((!m_rv || rready) && ei >= 0) begin
                m_rv  <= 1;
                m_rid <= t[ei].id;
                m_rd  <= t[ei].addr + 8'(t[ei].id);
                t[ei].v = 0;
            end else if (m_rv && rready) begin
                m_rv <= 0;
            end
            if (acc && fi >= 0) begin
                t[fi].v    = 1;
                t[fi].id   = arid;
                t[fi].addr = araddr;
                t[fi].due  = e + lat(arid);
            end
            m_tab <= t;
        end
    end

    always @(negedge clk) begin : compare
        #2;
        chk("arready", 32'(arready), 32'(m_ready()));
        chk("rvalid", 32'(rvalid), 32'(m_rv));
        if (m_rv) begin
            chk("rid", 32'(rid), 32'(m_rid));
            chk("rdata", 32'(rdata), 32'(m_rd));
        end
    end

    task automatic reset_pulse();
        @(negedge clk);
        arvalid = 1'b0;
        rst = 1'b1;
        #3;
        rst = 1'b0;
    endtask

    task automatic set_ar(bit v, bit [3:0] id, bit [7:0] addr);
        arvalid = v;
        arid = id;
        araddr = addr;
    endtask

    task automatic next_chk();
        @(negedge clk);
        #3;
    endtask

    task automatic lit_beat(string name, bit v, bit [3:0] id, bit [7:0] d);
        chk({name, "_valid"}, 32'(rvalid), 32'(v));
        if (v) begin
            chk({name, "_id"}, 32'(rid), 32'(id));
            chk({name, "_data"}, 32'(rdata), 32'(d));
        end
    endtask

    logic will_acc;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #3;
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_rid", 32'(rid), 32'd0);
        chk("rst_arready", 32'(arready), 32'd0);
        rst = 1'b0;

        // Single request, L=3: beat visible after N+4 for one cycle
        reset_pulse();
        @(negedge clk); set_ar(1, 4'd2, 8'h10); rready = 1'b1;
        @(negedge clk); arvalid = 1'b0; #3;
        lit_beat("t1_n0", 0, 0, 0);
        for (int k = 1; k <= 3; k++) begin next_chk(); lit_beat("t1_wait", 0, 0, 0); end
        next_chk(); lit_beat("t1_beat", 1, 4'd2, 8'h12);
        next_chk(); lit_beat("t1_after", 0, 0, 0);

        // Out-of-order return
        reset_pulse();
        @(negedge clk); set_ar(1, 4'd2, 8'h10); rready = 1'b1;
        @(negedge clk); set_ar(1, 4'd3, 8'h20);
        @(negedge clk); arvalid = 1'b0;
        next_chk(); lit_beat("t2_n2", 0, 0, 0);
        next_chk(); lit_beat("t2_first", 1, 4'd3, 8'h23);
        next_chk(); lit_beat("t2_second", 1, 4'd2, 8'h12);
        next_chk(); lit_beat("t2_after", 0, 0, 0);

        // Back-pressure holds the first beat, then both drain back-to-back
        reset_pulse();
        @(negedge clk); set_ar(1, 4'd2, 8'h10); rready = 1'b0;
        @(negedge clk); set_ar(1, 4'd3, 8'h20);
        @(negedge clk); arvalid = 1'b0;
        next_chk();
        for (int k = 0; k < 5; k++) begin next_chk(); lit_beat("t3_hold", 1, 4'd3, 8'h23); end
        rready = 1'b1;
        next_chk(); lit_beat("t3_second", 1, 4'd2, 8'h12);
        next_chk(); lit_beat("t3_after", 0, 0, 0);

        // ID blocking: id 5 (L=5) blocks a second id 5 until loaded at N+6
        reset_pulse();
        @(negedge clk); set_ar(1, 4'd5, 8'h40); rready = 1'b1;
        @(negedge clk); set_ar(1, 4'd5, 8'h41); #3;
        chk("t4_block0", 32'(arready), 32'd0);
        for (int k = 1; k <= 5; k++) begin next_chk(); chk("t4_block", 32'(arready), 32'd0); end
        next_chk();
        chk("t4_unblock", 32'(arready), 32'd1);
        lit_beat("t4_beat", 1, 4'd5, 8'h45);
        @(negedge clk); arvalid = 1'b0;
        repeat (12) @(negedge clk);

        // Full table: ids 4..7, then id 8 waits until a slot is freed
        reset_pulse();
        rready = 1'b0;
        @(negedge clk); set_ar(1, 4'd4, 8'h34);
        @(negedge clk); set_ar(1, 4'd5, 8'h35);
        @(negedge clk); set_ar(1, 4'd6, 8'h36);
        @(negedge clk); set_ar(1, 4'd7, 8'h37);
        @(negedge clk); set_ar(1, 4'd8, 8'h38); #3;
        chk("t5_full0", 32'(arready), 32'd0);
        next_chk(); chk("t5_full1", 32'(arready), 32'd0);
        next_chk();
        chk("t5_freed", 32'(arready), 32'd1);
        lit_beat("t5_beat", 1, 4'd7, 8'h3e);
        @(negedge clk); arvalid = 1'b0; rready = 1'b1;
        repeat (20) @(negedge clk);

        // Reset mid-flight with a beat held in the output register
        reset_pulse();
        rready = 1'b0;
        @(negedge clk); set_ar(1, 4'd1, 8'h51);
        @(negedge clk); set_ar(1, 4'd2, 8'h52);
        @(negedge clk); set_ar(1, 4'd3, 8'h53);
        @(negedge clk); arvalid = 1'b0;
        repeat (2) @(negedge clk);
        #3; lit_beat("t6_pre", 1, 4'd3, 8'h56);
        @(negedge clk); rst = 1'b1; #1;
        chk("t6_rst_rvalid", 32'(rvalid), 32'd0);
        chk("t6_rst_arready", 32'(arready), 32'd0);
        #2; rst = 1'b0; rready = 1'b1;
        for (int k = 0; k < 10; k++) begin next_chk(); chk("t6_quiet", 32'(rvalid), 32'd0); end

        // Randomized traffic with AR held until accepted
        will_acc = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 399) == 0) begin
                arvalid = 1'b0;
                will_acc = 1'b0;
                rst = 1'b1;
                #3;
                rst = 1'b0;
                continue;
            end
            if (!arvalid || will_acc) begin
                arvalid = ($urandom_range(0, 2) != 0);
                arid = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 5)) : 4'($urandom);
                araddr = 8'($urandom);
            end
            rready = ($urandom_range(0, 3) != 0);
            #1;
            will_acc = arvalid && arready;
        end

        @(negedge clk);
        arvalid = 1'b0;
        rready = 1'b1;
        repeat (40) @(negedge clk);
        #3;
        chk("drain_empty", 32'(rvalid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
